thread_scheduler: RTL and testbench
===================================

// Module: thread_scheduler
// PURPOSE
//  Per-thread PC table and round-robin issue scheduler for the barrel pipeline; replaces the fetch-stage PC select.
//  Each cycle it picks the next eligible hardware thread and presents its tid/PC to instruction fetch.
//  Applies execute-stage redirects, plus thread start/halt requests.
//  Enforces a per-thread reissue gap so a branch resolves before that thread fetches again.
// PARAMETERS
//  ADDRESS_WIDTH  32          PC width
//  NUM_THREADS    8           hardware threads; power of 2, >=2
//  RESET_PC       0           PC loaded into every thread at reset
//  RESET_MASK     all ones    active_mask value at reset (NUM_THREADS bits)
//  MIN_GAP        4           min edges between two issues of same thread (>=1)
//  (local) BITS_THREADS = $clog2(NUM_THREADS)
// PORTS
//  clk             in   1             clock; all state on rising edge
//  rst             in   1             asynchronous, active-low reset
//  stall           in   1             1 = hold issue outputs, no issue this edge
//  redirect_valid  in   1             taken branch/jump from execute (pc_src_e)
//  redirect_tid    in   BITS_THREADS  thread being redirected
//  redirect_pc     in   ADDRESS_WIDTH target PC
//  start_valid     in   1             activate thread
//  start_tid       in   BITS_THREADS  thread to start
//  start_pc        in   ADDRESS_WIDTH start PC
//  halt_valid      in   1             deactivate thread
//  halt_tid        in   BITS_THREADS  thread to halt
//  issue_valid     out  1             issue_tid/issue_pc valid this cycle (registered)
//  issue_tid       out  BITS_THREADS  thread being fetched
//  issue_pc        out  ADDRESS_WIDTH PC to fetch
//  active_mask     out  NUM_THREADS   bit i = thread i active
//  idle            out  1             active_mask == 0 (combinational)
// BEHAVIOUR
//  Reset (rst=0, async, effect immediate): issue_valid=0, issue_tid=0, issue_pc=RESET_PC, every pc_table entry=RESET_PC,
//   active_mask=RESET_MASK, all gap counters=0, last_tid=NUM_THREADS-1 (first issue is tid 0). Reset mid-run discards all state.
//  Eligibility: thread i eligible iff active_mask[i] && gap_cnt[i]==0; evaluated on registered state only.
//  Selection (edge with stall=0): first eligible tid in order last_tid+1, +2 ... wrapping mod NUM_THREADS.
//   If found: issue_valid<=1, issue_tid<=sel, issue_pc<=sel_pc, pc_table[sel]<=sel_pc+4 (mod 2^ADDRESS_WIDTH),
//   last_tid<=sel, gap_cnt[sel]<=MIN_GAP-1. If none: issue_valid<=0 (bubble), issue_tid/issue_pc/last_tid hold.
//  sel_pc bypass priority: start_valid&&start_tid==sel -> start_pc; else redirect_valid&&redirect_tid==sel -> redirect_pc;
//   else pc_table[sel].
//  Gap counters: every edge (incl. stall), each nonzero gap_cnt decrements by 1. Thread issued at edge t next eligible at t+MIN_GAP.
//  stall=1: issue_valid/issue_tid/issue_pc, last_tid, pc_table increments all held. Start/halt/redirect still applied.
//  Redirect (non-selected tid, or any tid during stall): pc_table[redirect_tid]<=redirect_pc; active_mask unchanged.
//   A redirect to an inactive thread only updates its PC.
//  Start: active_mask[start_tid]<=1, pc_table[start_tid]<=start_pc (start_pc+4 if issued same edge); gap_cnt unchanged.
//   A started thread is first eligible on the next edge. Start to an already-active thread = PC overwrite.
//  Halt: active_mask[halt_tid]<=0. Halt does not block an issue of that tid on the same edge; no later issues.
//  Simultaneous, same tid: start beats halt and redirect; redirect beats the +4 increment.
//  Halting all threads: issue_valid falls to 0 on the next non-stalled edge; idle=1 once mask clears.
//  No internal flush: wrong-path suppression relies on MIN_GAP >= edges from issue to execute redirect.
// TESTING
//  T1 reset, RESET_MASK=all, RESET_PC=0, NUM_THREADS=8, MIN_GAP=4 -> tids 0..7 at pc 0, then 0..7 at pc 4; issue_valid=1 each edge.
//  T2 halt all but tid 2 -> issue_valid pattern 1,0,0,0 repeating; tid 2 PCs 0x8,0xC,0x10...; idle=0.
//  T3 redirect tid 2 -> 0x100 on the edge tid 2 is selected -> issue_pc=0x100; next tid 2 issue at 0x104.
//  T4 stall=1 for 3 edges mid-round (last issue tid 3) -> outputs frozen at tid 3; after release next issue is tid 4, PC unchanged.
//  T5 halt all -> issue_valid=0, idle=1; start tid 5 pc 0x40 -> next edge issue tid 5 pc 0x40, then 0x44 after MIN_GAP.
//  T6 start+halt tid 6 same edge -> tid 6 active; assert rst mid-run -> issue_valid=0, issue_pc=RESET_PC immediately.

Source files
------------

// File: rtl/thread_scheduler.sv
// thread_scheduler: per-thread PC table and round-robin issue selector for the
// barrel pipeline. Each cycle the next eligible hardware thread (active and out
// of its reissue gap) is presented to instruction fetch with its PC. Execute
// redirects and start/halt requests update the table, with same-edge bypass.
module thread_scheduler #(
  parameter int                          ADDRESS_WIDTH = 32,
  parameter int                          NUM_THREADS   = 8,
  parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC      = '0,
  parameter logic [NUM_THREADS-1:0]      RESET_MASK    = '1,
  parameter int                          MIN_GAP       = 4,
  localparam int                         BITS_THREADS  = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [BITS_THREADS-1:0]  redirect_tid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     start_valid,
  input  logic [BITS_THREADS-1:0]  start_tid,
  input  logic [ADDRESS_WIDTH-1:0] start_pc,
  input  logic                     halt_valid,
  input  logic [BITS_THREADS-1:0]  halt_tid,
  output logic                     issue_valid,
  output logic [BITS_THREADS-1:0]  issue_tid,
  output logic [ADDRESS_WIDTH-1:0] issue_pc,
  output logic [NUM_THREADS-1:0]   active_mask,
  output logic                     idle
);

  // Gap counter only needs to hold MIN_GAP-1; keep at least one bit.
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

  logic [ADDRESS_WIDTH-1:0] pc_table [NUM_THREADS];
  logic [NUM_THREADS-1:0]   eligible;
  logic [BITS_THREADS-1:0]  last_tid_reg;
  logic [BITS_THREADS-1:0]  sel_tid;
  logic [BITS_THREADS-1:0]  cand_tid;
  logic                     sel_found;
  logic                     issue_fire;
  logic [ADDRESS_WIDTH-1:0] sel_pc;

  // Round-robin search starting just after the last issued thread; the
  // BITS_THREADS-wide addition wraps modulo NUM_THREADS for free.
  always_comb begin
    sel_found = 1'b0;
    sel_tid   = last_tid_reg;
    cand_tid  = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      cand_tid = last_tid_reg + BITS_THREADS'(k);
      if (!sel_found && eligible[cand_tid]) begin
        sel_found = 1'b1;
        sel_tid   = cand_tid;
      end
    end
  end

  assign issue_fire = sel_found && !stall;

  // PC for the selected thread, bypassing same-edge start and redirect.
  always_comb begin
    if (start_valid && start_tid == sel_tid) begin
      sel_pc = start_pc;
    end else if (redirect_valid && redirect_tid == sel_tid) begin
      sel_pc = redirect_pc;
    end else begin
      sel_pc = pc_table[sel_tid];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      logic [ADDRESS_WIDTH-1:0] pc_reg;
      logic [GAP_W-1:0]         gap_reg;
      logic                     mask_reg;
      logic                     issued_here;
      logic                     start_here;
      logic                     redirect_here;
      logic                     halt_here;

      assign issued_here   = issue_fire && (sel_tid == BITS_THREADS'(gi));
      assign start_here    = start_valid && (start_tid == BITS_THREADS'(gi));
      assign redirect_here = redirect_valid && (redirect_tid == BITS_THREADS'(gi));
      assign halt_here     = halt_valid && (halt_tid == BITS_THREADS'(gi));

      assign pc_table[gi]    = pc_reg;
      assign active_mask[gi] = mask_reg;
      assign eligible[gi]    = mask_reg && (gap_reg == '0);

      // Per-thread PC, reissue gap and active bit; an issue consumes the
      // bypassed PC (start > redirect > table) and reloads the gap.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pc_reg   <= RESET_PC;
          gap_reg  <= '0;
          mask_reg <= RESET_MASK[gi];
        end else begin
          if (issued_here) begin
            pc_reg  <= sel_pc + ADDRESS_WIDTH'(4);
            gap_reg <= GAP_RELOAD;
          end else begin
            if (start_here) begin
              pc_reg <= start_pc;
            end else if (redirect_here) begin
              pc_reg <= redirect_pc;
            end
            if (gap_reg != '0) begin
              gap_reg <= gap_reg - GAP_W'(1);
            end
          end
          if (start_here) begin
            mask_reg <= 1'b1;
          end else if (halt_here) begin
            mask_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Registered issue outputs; stall and empty selection both hold tid/pc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid  <= 1'b0;
      issue_tid    <= '0;
      issue_pc     <= RESET_PC;
      last_tid_reg <= BITS_THREADS'(NUM_THREADS - 1);
    end else if (!stall) begin
      if (sel_found) begin
        issue_valid  <= 1'b1;
        issue_tid    <= sel_tid;
        issue_pc     <= sel_pc;
        last_tid_reg <= sel_tid;
      end else begin
        issue_valid <= 1'b0;
      end
    end
  end

  assign idle = (active_mask == '0);

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler with default parameters (8 threads,
// MIN_GAP 4, RESET_PC 0, all threads active at reset).
module tb_thread_scheduler;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [2:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic        start_valid;
  logic [2:0]  start_tid;
  logic [31:0] start_pc;
  logic        halt_valid;
  logic [2:0]  halt_tid;
  logic        issue_valid;
  logic [2:0]  issue_tid;
  logic [31:0] issue_pc;
  logic [7:0]  active_mask;
  logic        idle;

  int vec_cnt = 0;
  int err_cnt = 0;

  thread_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_tid   (redirect_tid),
    .redirect_pc    (redirect_pc),
    .start_valid    (start_valid),
    .start_tid      (start_tid),
    .start_pc       (start_pc),
    .halt_valid     (halt_valid),
    .halt_tid       (halt_tid),
    .issue_valid    (issue_valid),
    .issue_tid      (issue_tid),
    .issue_pc       (issue_pc),
    .active_mask    (active_mask),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vec_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  task automatic check_issue(input string tag, input logic v,
                             input logic [2:0] tid, input logic [31:0] pc);
    check_value({tag, ".valid"}, 64'(issue_valid), 64'(v));
    check_value({tag, ".tid"},   64'(issue_tid),   64'(tid));
    check_value({tag, ".pc"},    64'(issue_pc),    64'(pc));
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  halt_list [7];
    logic [31:0] last_pc;
    halt_list = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    rst = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    start_valid = 1'b0; start_tid = '0; start_pc = '0;
    halt_valid = 1'b0; halt_tid = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_issue("reset", 1'b0, 3'd0, 32'h0);
    check_value("reset.mask", 64'(active_mask), 64'hFF);
    check_value("reset.idle", 64'(idle), 64'h0);
    rst = 1'b1;

    // T1: two full rounds, PC 0 then 4
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 8; t++) begin
        tick();
        check_issue($sformatf("t1.r%0d.t%0d", r, t), 1'b1, 3'(t), 32'(r * 4));
      end
    end

    // T4: third round up to tid 3, stall three edges, resume at tid 4
    for (int t = 0; t < 4; t++) begin
      tick();
      check_issue($sformatf("t4.pre.t%0d", t), 1'b1, 3'(t), 32'h8);
    end
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_issue($sformatf("t4.stall%0d", s), 1'b1, 3'd3, 32'h8);
    end
    stall = 1'b0;
    for (int t = 4; t < 8; t++) begin
      tick();
      check_issue($sformatf("t4.post.t%0d", t), 1'b1, 3'(t), 32'h8);
    end

    // T2: halt all but tid 2 (one per edge, under stall so outputs hold)
    stall = 1'b1;
    halt_valid = 1'b1;
    for (int h = 0; h < 7; h++) begin
      halt_tid = halt_list[h];
      tick();
      check_issue($sformatf("t2.halt%0d", h), 1'b1, 3'd7, 32'h8);
    end
    halt_valid = 1'b0;
    stall = 1'b0;
    check_value("t2.mask", 64'(active_mask), 64'h04);
    check_value("t2.idle", 64'(idle), 64'h0);
    last_pc = 32'h8;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k % 4 == 0) begin
        last_pc = 32'hC + 32'(4 * (k / 4));
        check_issue($sformatf("t2.e%0d", k), 1'b1, 3'd2, last_pc);
      end else begin
        check_issue($sformatf("t2.e%0d", k), 1'b0, 3'd2, last_pc);
      end
    end

    // T3: redirect tid 2 to 0x100 on the edge it is selected
    for (int k = 0; k < 3; k++) begin
      tick();
      check_value($sformatf("t3.gap%0d.valid", k), 64'(issue_valid), 64'h0);
    end
    redirect_valid = 1'b1; redirect_tid = 3'd2; redirect_pc = 32'h100;
    tick();
    check_issue("t3.redir", 1'b1, 3'd2, 32'h100);
    redirect_valid = 1'b0;
    repeat (3) tick();
    tick();
    check_issue("t3.next", 1'b1, 3'd2, 32'h104);

    // T5: halt on the issue edge still issues; then idle; start tid 5
    repeat (3) tick();
    halt_valid = 1'b1; halt_tid = 3'd2;
    tick();
    check_issue("t5.halt_issue", 1'b1, 3'd2, 32'h108);
    check_value("t5.mask", 64'(active_mask), 64'h00);
    check_value("t5.idle", 64'(idle), 64'h1);
    halt_valid = 1'b0;
    tick();
    check_value("t5.bubble.valid", 64'(issue_valid), 64'h0);
    start_valid = 1'b1; start_tid = 3'd5; start_pc = 32'h40;
    tick();
    check_value("t5.start.valid", 64'(issue_valid), 64'h0);
    check_value("t5.start.mask", 64'(active_mask), 64'h20);
    check_value("t5.start.idle", 64'(idle), 64'h0);
    start_valid = 1'b0;
    tick();
    check_issue("t5.first", 1'b1, 3'd5, 32'h40);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_value($sformatf("t5.gap%0d.valid", k), 64'(issue_valid), 64'h0);
    end
    tick();
    check_issue("t5.second", 1'b1, 3'd5, 32'h44);

    // T6: start beats halt for the same tid
    start_valid = 1'b1; start_tid = 3'd6; start_pc = 32'h200;
    halt_valid = 1'b1; halt_tid = 3'd6;
    tick();
    check_value("t6.mask", 64'(active_mask), 64'h60);
    check_value("t6.valid", 64'(issue_valid), 64'h0);
    start_valid = 1'b0; halt_valid = 1'b0;
    tick();
    check_issue("t6.issue", 1'b1, 3'd6, 32'h200);

    // Mid-run asynchronous reset takes effect without a clock edge
    #2;
    rst = 1'b0;
    #1;
    check_issue("t6.rst", 1'b0, 3'd0, 32'h0);
    check_value("t6.rst.mask", 64'(active_mask), 64'hFF);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_issue("t6.after_rst", 1'b1, 3'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
